// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with direction, atomic set/clear,
// synchronised + debounced inputs, rise/fall edge capture and level irq.
// Latency: bus reads combinational, writes take effect on the next clk edge;
// pad-in to DATA_IN <= SYNC_STAGES + 3*DEBOUNCE_DIV + 1 cycles.
// Backpressure: none, ready_out = sel_in (zero wait states).
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   address_in[4:2], sel_in    register select / slave select
//   read_in                    read strobe (reads have no side effects)
//   write_mask_in, write_value_in  byte-lane write enables and data
//   read_value_out, ready_out  read data (0 when not selected), ready
//   gpio_in/gpio_out/gpio_oe   raw pad inputs, pad outputs, pad enables
//   irq_out                    registered |EVENT
module gpio_bank #(
    parameter int              WIDTH        = 8,
    parameter int              SYNC_STAGES  = 2,
    parameter int              DEBOUNCE_DIV = 36000,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      address_in,
    input  logic             sel_in,
    input  logic             read_in,
    output logic [31:0]      read_value_out,
    input  logic [3:0]       write_mask_in,
    input  logic [31:0]      write_value_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_out
);

    localparam int CW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DEBOUNCE_DIV - 1);

    localparam logic [2:0] R_DATA_OUT = 3'd0;
    localparam logic [2:0] R_DATA_IN  = 3'd1;
    localparam logic [2:0] R_DIR      = 3'd2;
    localparam logic [2:0] R_RISE_EN  = 3'd3;
    localparam logic [2:0] R_FALL_EN  = 3'd4;
    localparam logic [2:0] R_EVENT    = 3'd5;
    localparam logic [2:0] R_SET      = 3'd6;
    localparam logic [2:0] R_CLR      = 3'd7;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] event_q, event_d;
    logic             irq_q, irq_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] hist0_q, hist0_d;
    logic [WIDTH-1:0] hist1_q, hist1_d;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] filt_prev_q, filt_prev_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             tick;
    logic             wr;
    logic [2:0]       reg_idx;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] ev_set;
    logic [WIDTH-1:0] rd_val;

    // Only address[4:2] is decoded and reads have no side effects.
    logic unused_ok;
    assign unused_ok = ^{read_in, address_in, write_value_in};

    assign reg_idx   = address_in[4:2];
    assign wr        = sel_in & (|write_mask_in);
    assign sync_val  = sync_q[SYNC_STAGES-1];
    assign tick      = (cnt_q == TICK_LAST);

    always_comb begin
        wmask = '0;
        wbits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            wmask[i] = write_mask_in[i/8];
            wbits[i] = write_value_in[i] & write_mask_in[i/8];
        end
    end

    always_comb begin
        data_out_d  = data_out_q;
        dir_d       = dir_q;
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        hist0_d     = hist0_q;
        hist1_d     = hist1_q;
        filt_d      = filt_q;
        filt_prev_d = filt_q;
        irq_d       = |event_q;

        sync_d[0] = gpio_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end

        // Filter moves to v only when two stored samples and the current
        // sample agree on v; otherwise it holds.
        if (tick) begin
            hist0_d = sync_val;
            hist1_d = hist0_q;
            filt_d  = (filt_q | (hist0_q & hist1_q & sync_val))
                    & (hist0_q | hist1_q | sync_val);
        end

        ev_set  = (filt_q & ~filt_prev_q & rise_en_q)
                | (~filt_q & filt_prev_q & fall_en_q);
        event_d = event_q;

        if (wr) begin
            unique case (reg_idx)
                R_DATA_OUT: data_out_d = (data_out_q & ~wmask) | wbits;
                R_DIR:      dir_d      = (dir_q & ~wmask) | wbits;
                R_RISE_EN:  rise_en_d  = (rise_en_q & ~wmask) | wbits;
                R_FALL_EN:  fall_en_d  = (fall_en_q & ~wmask) | wbits;
                R_EVENT:    event_d    = event_q & ~wbits;
                R_SET:      data_out_d = data_out_q | wbits;
                R_CLR:      data_out_d = data_out_q & ~wbits;
                default:    ;
            endcase
        end
        // A new edge in the same cycle as a W1C keeps the bit set.
        event_d = event_d | ev_set;
    end

    always_comb begin
        rd_val = '0;
        unique case (reg_idx)
            R_DATA_OUT: rd_val = data_out_q;
            R_DATA_IN:  rd_val = filt_q;
            R_DIR:      rd_val = dir_q;
            R_RISE_EN:  rd_val = rise_en_q;
            R_FALL_EN:  rd_val = fall_en_q;
            R_EVENT:    rd_val = event_q;
            default:    rd_val = '0;
        endcase
    end

    assign read_value_out = sel_in ? 32'(rd_val) : 32'd0;
    assign ready_out      = sel_in;
    assign gpio_out       = data_out_q;
    assign gpio_oe        = dir_q;
    assign irq_out        = irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q  <= RESET_OUT;
            dir_q       <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            event_q     <= '0;
            irq_q       <= 1'b0;
            sync_q      <= '0;
            hist0_q     <= '0;
            hist1_q     <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            cnt_q       <= '0;
        end else begin
            data_out_q  <= data_out_d;
            dir_q       <= dir_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            event_q     <= event_d;
            irq_q       <= irq_d;
            sync_q      <= sync_d;
            hist0_q     <= hist0_d;
            hist1_q     <= hist1_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
module tb_gpio_bank;

    localparam int         WIDTH = 8;
    localparam logic [7:0] RST_OUT = 8'h5A;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address_in = '0;
    logic        sel_in = 1'b0;
    logic        read_in = 1'b0;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in = '0;
    logic [31:0] write_value_in = '0;
    logic        ready_out;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq_out;

    always #5 clk = ~clk;

    gpio_bank #(
        .WIDTH(WIDTH), .SYNC_STAGES(2), .DEBOUNCE_DIV(4), .RESET_OUT(RST_OUT)
    ) dut (
        .clk(clk), .reset(reset), .address_in(address_in), .sel_in(sel_in),
        .read_in(read_in), .read_value_out(read_value_out),
        .write_mask_in(write_mask_in), .write_value_in(write_value_in),
        .ready_out(ready_out), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_oe(gpio_oe), .irq_out(irq_out)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", t, obs, e);
        end
    endtask

    task automatic do_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        sel_in = 1'b1; address_in = off; write_value_in = d; write_mask_in = m;
        @(posedge clk);
        #1;
        sel_in = 1'b0; write_mask_in = '0; write_value_in = '0;
    endtask

    task automatic do_read(input logic [31:0] off, output logic [31:0] d);
        @(negedge clk);
        sel_in = 1'b1; read_in = 1'b1; address_in = off; write_mask_in = '0;
        #1;
        d = read_value_out;
        sel_in = 1'b0; read_in = 1'b0;
    endtask

    task automatic wait_din(input int b, input logic v, input int bound, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            sel_in = 1'b1; address_in = 32'h04;
            #1;
            if (read_value_out[b] === v) seen = 1'b1;
            sel_in = 1'b0;
        end
    endtask

    task automatic stable_din(input int b, input logic v, input int cycles, output logic ok);
        ok = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            sel_in = 1'b1; address_in = 32'h04;
            #1;
            if (read_value_out[b] !== v) ok = 1'b0;
            sel_in = 1'b0;
        end
    endtask

    task automatic wait_event(input logic [31:0] v, input int bound, output logic seen, output logic irq_at);
        seen = 1'b0;
        irq_at = 1'bx;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            sel_in = 1'b1; address_in = 32'h14;
            #1;
            if (read_value_out === v) begin
                seen = 1'b1;
                irq_at = irq_out;
            end
            sel_in = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        seen;
        logic        ok;
        logic        irq_at;
        logic [31:0] rst_exp [8];

        rst_exp = '{32'(RST_OUT), 0, 0, 0, 0, 0, 0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        push("oe_in_reset", 0);   check(32'(gpio_oe));
        push("irq_in_reset", 0);  check(32'(irq_out));
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            push($sformatf("reset_read_%0d", k), rst_exp[k]);
            do_read(32'(k * 4), rd);
            check(rd);
        end
        push("gpio_out_reset", 32'(RST_OUT)); check(32'(gpio_out));
        @(negedge clk); sel_in = 1'b1; address_in = 32'h0; #1;
        push("ready_sel1", 1);    check(32'(ready_out));
        sel_in = 1'b0; #1;
        push("ready_sel0", 0);    check(32'(ready_out));
        push("rdata_sel0", 0);    check(read_value_out);

        // Data out, set, clear on successive cycles
        do_write(32'h00, 32'h0000_00A5, 4'b0001);
        push("dout_write", 32'hA5); check(32'(gpio_out));
        do_write(32'h18, 32'h0000_000A, 4'b0001);
        push("dout_set", 32'hAF);   check(32'(gpio_out));
        do_write(32'h1C, 32'h0000_0081, 4'b0001);
        push("dout_clr", 32'h2E);   check(32'(gpio_out));
        do_write(32'h00, 32'hFFFF_FFFF, 4'b0010);
        push("dout_lane1_only", 32'h2E); check(32'(gpio_out));
        push("set_reads_zero", 0);  do_read(32'h18, rd); check(rd);

        // Direction; bits above WIDTH ignored
        do_write(32'h08, 32'hFFFF_FFFF, 4'b1111);
        push("dir_readback", 32'hFF); do_read(32'h08, rd); check(rd);
        push("oe_all", 32'hFF);       check(32'(gpio_oe));

        // Debounce: 5-cycle glitch rejected, held level accepted
        @(negedge clk); gpio_in[3] = 1'b1;
        repeat (5) @(negedge clk);
        gpio_in[3] = 1'b0;
        stable_din(3, 1'b0, 20, ok);
        push("glitch_rejected", 1); check(32'(ok));
        @(negedge clk); gpio_in[3] = 1'b1;
        wait_din(3, 1'b1, 15, seen);
        push("din_rise_latency", 1); check(32'(seen));

        // Enabling RISE_EN while high does not flag the current level
        do_write(32'h0C, 32'h08, 4'b0001);
        repeat (3) @(negedge clk);
        push("no_retro_event", 0); do_read(32'h14, rd); check(rd);
        @(negedge clk); gpio_in[3] = 1'b0;
        wait_din(3, 1'b0, 15, seen);
        push("din_fall", 1); check(32'(seen));
        repeat (2) @(negedge clk);
        push("fall_not_enabled", 0); do_read(32'h14, rd); check(rd);

        // Rise event, irq one cycle later, W1C
        @(negedge clk); gpio_in[3] = 1'b1;
        wait_event(32'h08, 20, seen, irq_at);
        push("rise_event", 1);       check(32'(seen));
        push("irq_not_yet", 0);      check(32'(irq_at));
        @(negedge clk); #1;
        push("irq_next_cycle", 1);   check(32'(irq_out));
        do_write(32'h14, 32'h08, 4'b0001);
        push("event_w1c", 0); do_read(32'h14, rd); check(rd);
        @(posedge clk); #1;
        push("irq_cleared", 0);      check(32'(irq_out));

        // W1C colliding with a new rise: set wins
        do_write(32'h10, 32'h08, 4'b0001);
        @(negedge clk); gpio_in[3] = 1'b0;
        wait_event(32'h08, 20, seen, irq_at);
        push("fall_event", 1); check(32'(seen));
        @(negedge clk); gpio_in[3] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15 && !seen; i++) begin
            @(negedge clk);
            sel_in = 1'b1; address_in = 32'h04; write_mask_in = '0;
            #1;
            if (read_value_out[3] === 1'b1) begin
                seen = 1'b1;
                address_in = 32'h14; write_value_in = 32'h08; write_mask_in = 4'b0001;
                @(posedge clk);
                #1;
                write_mask_in = '0; write_value_in = '0;
            end
            sel_in = 1'b0;
        end
        push("collide_rise_seen", 1); check(32'(seen));
        push("set_wins_w1c", 32'h08); do_read(32'h14, rd); check(rd);
        @(negedge clk); #1;
        push("irq_held", 1); check(32'(irq_out));

        // Asynchronous reset with irq pending and pads driven
        gpio_in = '0;
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        push("async_oe_drop", 0);     check(32'(gpio_oe));
        push("async_irq_drop", 0);    check(32'(irq_out));
        push("async_dout", 32'(RST_OUT)); check(32'(gpio_out));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            push($sformatf("post_reset_read_%0d", k), rst_exp[k]);
            do_read(32'(k * 4), rd);
            check(rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
